// File: rtl/ram_bridge_pkg.sv
// Shared types for the Ram4Kb request bridge: FSM state encoding and the
// packed command-entry width {write, addr, wdata}.
package ram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
    return 32'd1 + aw + dw;
  endfunction

endpackage

// File: rtl/ram_cmd_fifo.sv
// Synchronous command FIFO with wrapping pointers (one extra bit tells full from empty).
// ready_o is registered so it reads 0 while reset is held and 1 the cycle after release.
module ram_cmd_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         ready_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic         ready_q;
  logic         full_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    full_d = (wr_ptr_d[PW] != rd_ptr_d[PW]) && (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= !full_d;
    end
  end

  // Storage needs no reset: a flush only moves the pointers.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q[PW-1:0]] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q[PW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign ready_o = ready_q;

endmodule

// File: rtl/ram4kb_req_bridge.sv
// Host-side front-end for the Ram4Kb memory: queues commands, replays them one at a
// time over the RAM valid/ready port and returns one response per command.
module ram4kb_req_bridge
  import ram_bridge_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_write_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [DW-1:0] cmd_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic          rsp_write_o,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_error_o,
  output logic          rsp_tmo_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_write_o,
  output logic          mem_valid_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  input  logic          mem_error_i
);

  localparam int unsigned CMD_W = cmd_width(AW, DW);
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = (TIMEOUT == 0) ? {CNT_W{1'b1}} : CNT_W'(TIMEOUT);
  // cnt_q counts REQ cycles already completed, so the watchdog fires at the end of cycle TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_valid_q, mem_write_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_wdata_q;
  logic             rsp_valid_q, rsp_write_q, rsp_error_q, rsp_tmo_q;
  logic [DW-1:0]    rsp_rdata_q;

  logic             push, pop, fifo_empty, fifo_ready;
  logic [CMD_W-1:0] head;
  logic             head_write;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_wdata;

  assign push = cmd_valid_i && fifo_ready;
  assign pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign {head_write, head_addr, head_wdata} = head;

  ram_cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  ({cmd_write_i, cmd_addr_i, cmd_wdata_i}),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .ready_o (fifo_ready)
  );

  // Request/response FSM with watchdog; every output is a register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mem_write_q <= head_write;
            mem_addr_q  <= head_addr;
            mem_wdata_q <= head_wdata;
            mem_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= mem_write_q;
            rsp_rdata_q <= mem_write_q ? '0 : mem_rdata_i;
            rsp_error_q <= mem_error_i;
            rsp_tmo_q   <= 1'b0;
            state_q     <= ST_RSP;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= mem_write_q;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            rsp_tmo_q   <= 1'b1;
            state_q     <= ST_RSP;
          end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          mem_valid_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = fifo_ready;
  assign mem_valid_o = mem_valid_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_write_o = rsp_write_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign rsp_tmo_o   = rsp_tmo_q;

endmodule

// File: tb/tb_ram4kb_req_bridge.sv
// Bench for ram4kb_req_bridge: directed scenarios plus random traffic against an
// in-order command-queue reference model and a behavioural RAM device.
module tb_ram4kb_req_bridge;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_error, rsp_tmo;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_valid, mem_ready, mem_error;

  ram4kb_req_bridge #(.AW(16), .DW(16), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
    .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error), .rsp_tmo_o(rsp_tmo),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_write_o(mem_write),
    .mem_valid_o(mem_valid), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .mem_error_i(mem_error)
  );

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
  } cmd_t;

  cmd_t        cq[$];
  logic [15:0] shadow [logic [15:0]];
  logic [15:0] ram    [logic [15:0]];
  int total = 0, bad = 0, n_rsp = 0;
  int fixed_lat = 0, rsp_mode = 2;
  bit ram_hold = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic bit is_dead(input logic [15:0] a);
    return a[15:12] == 4'hF;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM device: addresses 0xF000.. never answer, 0x0800 answers with error.
  initial begin
    int wcnt, lat;
    wcnt = 0; lat = 0;
    mem_ready = 1'b0; mem_error = 1'b0; mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0; mem_error = 1'b0; mem_rdata = 16'h0000;
      if (!mem_valid) begin
        wcnt = 0;
        lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end else if (is_dead(mem_addr) || ram_hold || wcnt < lat) begin
        wcnt++;
      end else begin
        mem_ready = 1'b1;
        if (mem_addr == 16'h0800) begin
          mem_error = 1'b1;
          mem_rdata = 16'hDEAD;
        end else begin
          if (mem_write) ram[mem_addr] = mem_wdata;
          mem_rdata = ram.exists(mem_addr) ? ram[mem_addr] : init_val(mem_addr);
        end
        wcnt = 0;
      end
    end
  end

  // Response sink and scoreboard: commands retire strictly in acceptance order.
  initial begin
    cmd_t        c;
    logic [15:0] e_rdata;
    logic        e_err, e_tmo;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rsp_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
      if (rst_n && rsp_valid && rsp_ready) begin
        if (cq.size() == 0) begin
          check_val("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          c = cq.pop_front();
          e_tmo = 1'b0; e_err = 1'b0; e_rdata = 16'h0000;
          if (is_dead(c.a)) begin
            e_tmo = 1'b1; e_err = 1'b1;
          end else if (c.a == 16'h0800) begin
            e_err = 1'b1;
            e_rdata = c.w ? 16'h0000 : 16'hDEAD;
          end else if (c.w) begin
            shadow[c.a] = c.d;
          end else begin
            e_rdata = shadow.exists(c.a) ? shadow[c.a] : init_val(c.a);
          end
          check_val("rsp_write", rsp_write, c.w);
          check_val("rsp_rdata", rsp_rdata, e_rdata);
          check_val("rsp_error", rsp_error, e_err);
          check_val("rsp_tmo",   rsp_tmo,   e_tmo);
          n_rsp++;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d);
    int tries = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (!cmd_ready) begin
      check_val("push_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      cq.push_back('{w: w, a: a, d: d});
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((cq.size() != 0 || rsp_valid || mem_valid) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val("drain_q", cq.size(), 32'd0);
  endtask

  initial begin
    int base, req_cycles, k;
    logic [15:0] a;
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_wdata = 16'h0;

    // Reset held three cycles with a command offered
    repeat (3) @(negedge clk);
    check_val("rst_cmd_ready", cmd_ready, 1'b0);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_mem_valid", mem_valid, 1'b0);
    rst_n = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    check_val("rel_cmd_ready", cmd_ready, 1'b1);

    // Write then read, with E0->E2 latency checks
    fixed_lat = 0; rsp_mode = 2;
    push(1'b1, 16'h0005, 16'h0006);
    check_val("lat_e0_mem_valid", mem_valid, 1'b0);
    @(negedge clk);
    check_val("lat_e1_mem_valid", mem_valid, 1'b1);
    check_val("lat_e1_mem_addr",  mem_addr, 16'h0005);
    check_val("lat_e1_mem_write", mem_write, 1'b1);
    check_val("lat_e1_mem_wdata", mem_wdata, 16'h0006);
    @(negedge clk);
    check_val("lat_e2_rsp_valid", rsp_valid, 1'b1);
    push(1'b0, 16'h0005, 16'h0000);
    wait_drain(100);

    // Full FIFO while the RAM stalls, then five in-order responses
    ram_hold = 1'b1;
    base = n_rsp;
    for (int i = 0; i < 5; i++) push(1'b1, 16'h0010 + 16'(i), 16'($urandom));
    check_val("full_cmd_ready", cmd_ready, 1'b0);
    check_val("full_mem_valid", mem_valid, 1'b1);
    ram_hold = 1'b0;
    wait_drain(200);
    for (int i = 0; i < 5; i++) push(1'b0, 16'h0010 + 16'(i), 16'h0000);
    wait_drain(200);
    check_val("full_rsp_cnt", n_rsp - base, 32'd10);

    // Watchdog: RAM never ready
    push(1'b0, 16'hF000, 16'h0000);
    req_cycles = 0;
    for (k = 0; k < 40 && !rsp_valid; k++) begin
      if (mem_valid) req_cycles++;
      @(negedge clk);
    end
    check_val("tmo_rsp_valid", rsp_valid, 1'b1);
    check_val("tmo_req_cycles", req_cycles, 32'd8);
    push(1'b0, 16'h0005, 16'h0000);
    wait_drain(100);

    // RAM error with response backpressure; a queued command must not start
    rsp_mode = 1;
    push(1'b0, 16'h0800, 16'h0000);
    for (k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    push(1'b1, 16'h0003, 16'h1234);
    for (int i = 0; i < 10; i++) begin
      check_val("bp_rsp_valid", rsp_valid, 1'b1);
      check_val("bp_rsp_error", rsp_error, 1'b1);
      check_val("bp_rsp_tmo",   rsp_tmo,   1'b0);
      check_val("bp_rsp_rdata", rsp_rdata, 16'hDEAD);
      check_val("bp_rsp_write", rsp_write, 1'b0);
      check_val("bp_mem_valid", mem_valid, 1'b0);
      @(negedge clk);
    end
    rsp_mode = 2;
    wait_drain(100);

    // Reset while a request is outstanding and another is queued
    push(1'b1, 16'hF123, 16'hBEEF);
    push(1'b1, 16'h0007, 16'h7777);
    for (k = 0; k < 20 && !mem_valid; k++) @(negedge clk);
    check_val("mr_mem_valid_pre", mem_valid, 1'b1);
    rst_n = 1'b0;
    cq.delete();
    @(negedge clk);
    check_val("mr_mem_valid", mem_valid, 1'b0);
    check_val("mr_cmd_ready", cmd_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("mr_rel_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check_val("mr_no_rsp", rsp_valid, 1'b0);
      check_val("mr_fifo_empty", mem_valid, 1'b0);
      @(negedge clk);
    end
    push(1'b0, 16'h0007, 16'h0000);
    wait_drain(100);

    // Random traffic with random RAM latency and response backpressure
    rsp_mode = 0; fixed_lat = -1;
    for (int i = 0; i < 150; i++) begin
      k = int'($urandom_range(0, 99));
      if (k < 3)      a = 16'hF000 | 16'($urandom_range(0, 255));
      else if (k < 8) a = 16'h0800;
      else            a = 16'($urandom_range(0, 15));
      push(1'($urandom), a, 16'($urandom));
    end
    wait_drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
